hidden_layer_mac_ctrl: RTL

//  Sequencer + MAC for the SNN hidden layer; sits directly downstream of the hidden-weight ROM.
//  Per hidden neuron it streams 784 weight/input pairs, issuing addresses to the ROM and input RAM.

---
 rtl/hidden_layer_mac_ctrl_pkg.sv | 26 ++
 rtl/hidden_layer_mac_ctrl_if.sv | 34 +++
 rtl/hidden_layer_mac_ctrl_mac.sv | 47 ++++
 rtl/hidden_layer_mac_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/hidden_layer_mac_ctrl_pkg.sv
// Shared constants and types for the SNN hidden-layer sequencer/MAC.
// Dimensions: 784 inputs per neuron, 32 hidden neurons, 8-bit data,
// 17-bit signed products and a 27-bit signed accumulator. The accumulator
// is wide enough for 784 worst-case products, so it cannot overflow.
package hidden_layer_mac_ctrl_pkg;

  localparam int N_IN   = 784;
  localparam int N_HID  = 32;
  localparam int SHIFT  = 7;
  localparam int ROM_AW = 15;
  localparam int X_AW   = 10;
  localparam int H_AW   = 5;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int PROD_W = 17;
  localparam int ACC_W  = 27;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/hidden_layer_mac_ctrl_if.sv
// Bus bundle for the hidden-layer sequencer.
// Signals:
//   start           control pulse into the sequencer
//   busy, done      sequencer status
//   w_addr / w_q    hidden-weight ROM address and its signed data (1-cycle read)
//   x_addr / x_q    input RAM address and its unsigned data (1-cycle read)
//   h_we/h_addr/h_data  write port into the hidden result RAM
// The master modport is the sequencer side; the slave modport is the
// memories/controller side.
interface hidden_layer_mac_ctrl_if;
  import hidden_layer_mac_ctrl_pkg::*;

  logic                     start;
  logic                     busy;
  logic                     done;
  logic [ROM_AW-1:0]        w_addr;
  logic signed [COEF_W-1:0] w_q;
  logic [X_AW-1:0]          x_addr;
  logic [DATA_W-1:0]        x_q;
  logic                     h_we;
  logic [H_AW-1:0]          h_addr;
  logic signed [DATA_W-1:0] h_data;

  modport master (
    input  start, w_q, x_q,
    output busy, done, w_addr, x_addr, h_we, h_addr, h_data
  );

  modport slave (
    output start, w_q, x_q,
    input  busy, done, w_addr, x_addr, h_we, h_addr, h_data
  );

endinterface

// File: rtl/hidden_layer_mac_ctrl_mac.sv
// snn_mac: signed-weight x unsigned-input multiply-accumulate.
// Ports:
//   clk    clock, posedge
//   clr_i  synchronous clear of the accumulator; it has priority over en_i
//   en_i   accumulate the current product
//   w_i    signed 8-bit weight
//   x_i    unsigned 8-bit input
//   acc_o  27-bit signed running sum
module snn_mac
  import hidden_layer_mac_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [COEF_W-1:0] w_i,
  input  logic [DATA_W-1:0]        x_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [PROD_W-1:0] w_ext;
  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_q;

  // p0: product of the operands, both brought to 17 bits. The full product
  // range (-32640..32385) fits in 17 bits, so the truncated result is exact.
  always_comb begin
    w_ext   = {{(PROD_W-COEF_W){w_i[COEF_W-1]}}, w_i};
    x_ext   = {{(PROD_W-DATA_W){1'b0}}, x_i};
    prod_p0 = w_ext * x_ext;
    acc_d   = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + {{(ACC_W-PROD_W){prod_p0[PROD_W-1]}}, prod_p0};
    end
  end

  // p1: accumulator register
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/hidden_layer_mac_ctrl.sv
// hidden_layer_mac_ctrl: sequencer and MAC for the SNN hidden layer.
// For each of the 32 neurons it streams 784 weight/input address pairs,
// accumulates the products, and then writes one saturated 8-bit result
// (acc >>> 7 clamped to [-128,127]) into the hidden result RAM.
// Ports:
//   clk  clock, posedge
//   rst  synchronous, active-high reset
//   bus  master side of hidden_layer_mac_ctrl_if. It carries start/busy/done,
//        the ROM and input-RAM read ports, and the result write port.
module hidden_layer_mac_ctrl
  import hidden_layer_mac_ctrl_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  hidden_layer_mac_ctrl_if.master bus
);

  localparam logic [X_AW-1:0]        IDX_LAST  = X_AW'(N_IN - 1);
  localparam logic [H_AW-1:0]        NEUR_LAST = H_AW'(N_HID - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-128);

  state_e                   state_q, state_d;
  logic [X_AW-1:0]          idx_q, idx_d;
  logic [ROM_AW-1:0]        w_addr_q, w_addr_d;
  logic [H_AW-1:0]          neuron_q, neuron_d;
  logic                     vld_p1_q;
  logic                     mac_clr;
  logic signed [ACC_W-1:0]  acc;

  function automatic logic signed [DATA_W-1:0] sat8(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> SHIFT;
    if (s > SAT_MAX) begin
      return SAT_MAX[DATA_W-1:0];
    end else if (s < SAT_MIN) begin
      return SAT_MIN[DATA_W-1:0];
    end else begin
      return s[DATA_W-1:0];
    end
  endfunction

  // State and counter registers. vld_p1_q marks the cycle in which ROM/RAM
  // data for the previous RUN cycle's addresses are present on w_q/x_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      w_addr_q <= '0;
      neuron_q <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      w_addr_q <= w_addr_d;
      neuron_q <= neuron_d;
      vld_p1_q <= (state_q == RUN);
    end
  end

  // Next state. w_addr is a free-running counter that never resets between
  // neurons, so neuron*N_IN + idx needs no multiplier.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    w_addr_d = w_addr_q;
    neuron_d = neuron_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = RUN;
          idx_d    = '0;
          w_addr_d = '0;
          neuron_d = '0;
        end
      end
      RUN: begin
        if (idx_q == IDX_LAST) begin
          state_d = DRAIN;
        end else begin
          idx_d    = idx_q + X_AW'(1);
          w_addr_d = w_addr_q + ROM_AW'(1);
        end
      end
      DRAIN: begin
        state_d = WRITE;
      end
      WRITE: begin
        if (neuron_q == NEUR_LAST) begin
          state_d = DONE;
        end else begin
          state_d  = RUN;
          neuron_d = neuron_q + H_AW'(1);
          idx_d    = '0;
          w_addr_d = w_addr_q + ROM_AW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs. h_we is masked by rst so a reset landing on a WRITE cycle
  // never produces a partial write.
  always_comb begin
    bus.busy   = (state_q != IDLE);
    bus.done   = (state_q == DONE);
    bus.h_we   = (state_q == WRITE) && !rst;
    bus.h_addr = neuron_q;
    bus.h_data = (state_q == WRITE) ? sat8(acc) : '0;
    bus.w_addr = w_addr_q;
    bus.x_addr = idx_q;
  end

  // The accumulator clears on reset, on an accepted start, and after each
  // result has been written.
  assign mac_clr = rst || ((state_q == IDLE) && bus.start) || (state_q == WRITE);

  snn_mac u_mac (
    .clk   (clk),
    .clr_i (mac_clr),
    .en_i  (vld_p1_q),
    .w_i   (bus.w_q),
    .x_i   (bus.x_q),
    .acc_o (acc)
  );

endmodule
